instruction_fetch: RTL and testbench

- Producer side of the instruction path: generates the PC stream and issues requests to instruction memory.
- Buffers returned words with their PCs and presents them to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushes buffered and in-flight instructions, and restarts at the new PC.
- Sits between instruction memory and the decoder.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 32 +++
 rtl/instruction_fetch_fifo.sv | 47 ++++
 rtl/instruction_fetch.sv | 127 ++++++++++++
 tb/tb_instruction_fetch.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared configuration for the instruction fetch slice: default widths, reset PC,
// buffer depth and the fetch FSM state encoding.
package instruction_fetch_pkg;

  localparam int          INST_WIDTH       = 32;
  localparam logic [31:0] RESET_PC         = 32'h0000_0000;
  localparam int          FETCH_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle between fetch, instruction memory, execute (redirects) and decode.
// Handshakes: imem beat transfers when imem_req_o && imem_gnt_i at a rising edge; decoder beat transfers when inst_valid_o && inst_ready_i at a rising edge, and a valid beat holds inst_o/pc_o stable until taken unless a redirect flushes it.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = instruction_fetch_pkg::INST_WIDTH
);

  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [INST_WIDTH-1:0] imem_rdata_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic [INST_WIDTH-1:0] inst_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic                  fetch_err_o;
  instruction_fetch_pkg::fetch_state_e dbg_state;

  modport master (
    output imem_req_o, imem_addr_o, inst_o, pc_o, inst_valid_o, fetch_err_o, dbg_state,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_o, pc_o, inst_valid_o, fetch_err_o, dbg_state,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, inst} entries with a flush that
// empties it in one cycle; flush takes priority over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC generation, credit-limited imem requests, response buffering
// and redirect flush. Optional misaligned-target halt under IFETCH_ALIGN_CHECK_EN.
module instruction_fetch #(
  parameter int                    INST_WIDTH = instruction_fetch_pkg::INST_WIDTH,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = instruction_fetch_pkg::RESET_PC,
  parameter int                    FIFO_DEPTH = instruction_fetch_pkg::FETCH_FIFO_DEPTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  instruction_fetch_if.master bus
);

  import instruction_fetch_pkg::fetch_state_e;
  import instruction_fetch_pkg::BOOT;
  import instruction_fetch_pkg::RUN;
  import instruction_fetch_pkg::HALT;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = ADDR_WIDTH + INST_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, resp_pc_q, redirect_target;
  logic [CW-1:0]         outstanding_q, discard_q, fifo_count;
  logic [EW-1:0]         fifo_head;
  logic                  fifo_empty;
  logic                  req, valid, fire, resp_take, push, pop;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic target_bad;
  logic err_q;
  assign redirect_target = bus.redirect_pc_i;
  assign target_bad      = bus.redirect_pc_i[1:0] != 2'b00;
`else
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = bus.redirect_pc_i[1:0];
  assign redirect_target     = {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HALT: begin
`ifdef IFETCH_ALIGN_CHECK_EN
        if (bus.redirect_i) state_d = target_bad ? HALT : RUN;
`else
        state_d = RUN;
`endif
      end
      default: state_d = BOOT;
    endcase
  end

  // Credit counts both buffered words and words still in flight, so pushes never overflow.
  always_comb begin
    req   = (state_q == RUN) && !bus.redirect_i &&
            ((int'(fifo_count) + int'(outstanding_q)) < FIFO_DEPTH);
    valid = !fifo_empty && !bus.redirect_i;
  end

  assign fire      = req && bus.imem_gnt_i;
  assign resp_take = bus.imem_rvalid_i && (outstanding_q != '0);
  assign push      = resp_take && (discard_q == '0) && !bus.redirect_i;
  assign pop       = valid && bus.inst_ready_i;

  // A redirect turns every word still in flight into a discard; req is low then, so no new grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_q + CW'(fire) - CW'(resp_take);
      if (bus.redirect_i) begin
        fetch_pc_q <= redirect_target;
        resp_pc_q  <= redirect_target;
        discard_q  <= outstanding_q - CW'(resp_take);
      end else begin
        if (fire) fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
        if (resp_take) begin
          if (discard_q != '0) discard_q <= discard_q - CW'(1);
          else                 resp_pc_q <= resp_pc_q + ADDR_WIDTH'(4);
        end
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)               err_q <= 1'b0;
    else if (bus.redirect_i) err_q <= target_bad;
  end
  assign bus.fetch_err_o = err_q;
`else
  assign bus.fetch_err_o = 1'b0;
`endif

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (bus.redirect_i),
    .push      (push),
    .push_data ({resp_pc_q, bus.imem_rdata_i}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = fetch_pc_q;
  assign bus.inst_valid_o = valid;
  assign bus.pc_o         = fifo_head[EW-1:INST_WIDTH];
  assign bus.inst_o       = fifo_head[INST_WIDTH-1:0];
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: random memory/decoder/redirect stimulus against a
// stream model (each target yields PCs T, T+4, ... carrying mem_word(pc)).
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  instruction_fetch #(
    .INST_WIDTH (IW),
    .ADDR_WIDTH (AW),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          n_tests, n_fail;
  int unsigned cyc, boot_cyc;
  int          gnt_pct, rv_pct, rdy_pct, redir_pct;
  logic [31:0] stall_addr;
  int          stall_left, stall_seen;
  bit          force_redir;
  logic [31:0] force_target;
  logic [31:0] exp_pc;
  bit          exp_err;
  int          pops, total_pops, first_valid, gnt_count;
  bit          saw_fffc, saw_wrap;
  logic [31:0] exp_q[$];
  int unsigned gnt_cyc_q[$];
  bit          p_valid, p_ready, p_redir, p_req, p_gnt;
  logic [31:0] p_pc, p_inst, p_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] target_of(input logic [31:0] t);
`ifdef IFETCH_ALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic logic [31:0] rand_target();
`ifdef IFETCH_ALIGN_CHECK_EN
    return $urandom & 32'hFFFF_FFFC;
`else
    return $urandom;
`endif
  endfunction

  task automatic drive_idle();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.inst_ready_i  = 1'b0;
  endtask

  task automatic do_reset(input bit spurious);
    rst = 1'b1;
    drive_idle();
    exp_q.delete();
    gnt_cyc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.imem_req_o), 0);
    check("rst_valid", 32'(bus.inst_valid_o), 0);
    check("rst_err", 32'(bus.fetch_err_o), 0);
    check("rst_addr", bus.imem_addr_o, 32'h0000_0000);
    rst         = 1'b0;
    exp_pc      = 32'h0000_0000;
    exp_err     = 1'b0;
    boot_cyc    = cyc;
    first_valid = -1;
    pops        = 0;
    gnt_count   = 0;
    {p_valid, p_ready, p_redir, p_req, p_gnt} = '0;
    // Stray response during BOOT must not land in the buffer.
    if (spurious) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic step();
    logic        req, gnt, valid, ready, redir, err;
    logic [31:0] addr, pc, inst, resp_addr;
    bit          err_next;
    int unsigned rel;
    @(negedge clk);
    rel   = cyc - boot_cyc;
    req   = bus.imem_req_o;
    gnt   = bus.imem_gnt_i;
    addr  = bus.imem_addr_o;
    valid = bus.inst_valid_o;
    ready = bus.inst_ready_i;
    redir = bus.redirect_i;
    pc    = bus.pc_o;
    inst  = bus.inst_o;
    err   = bus.fetch_err_o;
    err_next = exp_err;
    if (rel == 0) check("boot_req", 32'(req), 0);
    check("fetch_err", 32'(err), 32'(exp_err));
    if (redir) begin
      check("redir_req", 32'(req), 0);
      check("redir_valid", 32'(valid), 0);
    end
    if (exp_err) begin
      check("halt_req", 32'(req), 0);
      check("halt_valid", 32'(valid), 0);
    end
    if (p_req && !p_gnt && !p_redir && !redir) begin
      check("hold_req", 32'(req), 1);
      check("hold_addr", addr, p_addr);
    end
    if (p_valid && !p_ready && !p_redir && !redir) begin
      check("stable_valid", 32'(valid), 1);
      check("stable_pc", pc, p_pc);
      check("stable_inst", inst, p_inst);
    end
    if (req && gnt) begin
      exp_q.push_back(addr);
      gnt_cyc_q.push_back(cyc);
      gnt_count++;
      check("credit", 32'(exp_q.size() <= DEPTH), 1);
      check("req_align", 32'(addr[1:0]), 0);
    end
    if (valid && ready && !redir) begin
      if (first_valid < 0) first_valid = int'(rel);
      check("pop_pc", pc, exp_pc);
      check("pop_inst", inst, mem_word(exp_pc));
      if (exp_pc == 32'hFFFF_FFFC) saw_fffc = 1'b1;
      else if (exp_pc == 32'h0 && saw_fffc) saw_wrap = 1'b1;
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redir) begin
      exp_pc = target_of(bus.redirect_pc_i);
`ifdef IFETCH_ALIGN_CHECK_EN
      err_next = (bus.redirect_pc_i[1:0] != 2'b00);
`endif
    end
    p_valid = valid; p_ready = ready; p_redir = redir; p_req = req; p_gnt = gnt;
    p_pc = pc; p_inst = inst; p_addr = addr;

    @(posedge clk);
    cyc++;
    exp_err = err_next;
    #1;
    if (force_redir) begin
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = force_target;
      force_redir       = 1'b0;
    end else if (int'($urandom_range(0, 99)) < redir_pct) begin
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = rand_target();
    end else begin
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = $urandom;
    end
    bus.inst_ready_i = int'($urandom_range(0, 99)) < rdy_pct;
    if (exp_q.size() > 0 && gnt_cyc_q[0] < cyc && int'($urandom_range(0, 99)) < rv_pct) begin
      resp_addr = exp_q.pop_front();
      void'(gnt_cyc_q.pop_front());
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(resp_addr);
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
    end
    #1;
    if (bus.imem_req_o && bus.imem_addr_o == stall_addr && stall_left > 0) begin
      bus.imem_gnt_i = 1'b0;
      stall_left--;
      stall_seen++;
    end else begin
      bus.imem_gnt_i = int'($urandom_range(0, 99)) < gnt_pct;
    end
  endtask

  task automatic set_knobs(input int g, input int r, input int d, input int x);
    gnt_pct = g; rv_pct = r; rdy_pct = d; redir_pct = x;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; total_pops = 0;
    force_redir = 1'b0; stall_left = 0; stall_seen = 0; stall_addr = 32'h1;
    saw_fffc = 1'b0; saw_wrap = 1'b0;
    rst = 1'b1;
    drive_idle();

    // Back-to-back fetch: first word valid three cycles after BOOT.
    set_knobs(100, 100, 100, 0);
    do_reset(1'b1);
    repeat (10) step();
    check("t1_first_valid", 32'(first_valid), 3);
    check("t1_progress", 32'(pops >= 3), 1);

    // Decoder stall: credit caps requests, head held, nothing lost afterwards.
    set_knobs(100, 100, 0, 0);
    do_reset(1'b0);
    repeat (8) step();
    check("t2_gnts", 32'(gnt_count), DEPTH);
    check("t2_head_valid", 32'(bus.inst_valid_o), 1);
    check("t2_head_pc", bus.pc_o, 32'h0);
    check("t2_head_inst", bus.inst_o, mem_word(32'h0));
    rdy_pct = 100;
    repeat (12) step();
    check("t2_progress", 32'(pops >= 4), 1);

    // Grant stall at 0x8 for three cycles.
    set_knobs(100, 100, 100, 0);
    do_reset(1'b0);
    stall_addr = 32'h8; stall_left = 3; stall_seen = 0;
    repeat (14) step();
    check("t3_stall_cycles", 32'(stall_seen), 3);
    check("t3_progress", 32'(pops >= 4), 1);
    stall_addr = 32'h1;

    // Redirect with two responses in flight: both dropped.
    set_knobs(100, 0, 100, 0);
    do_reset(1'b0);
    repeat (4) step();
    check("t4_in_flight", 32'(exp_q.size()), 2);
    force_redir = 1'b1; force_target = 32'h0000_0100;
    step();
    rv_pct = 100;
    pops = 0;
    repeat (12) step();
    check("t4_progress", 32'(pops >= 2), 1);
    check("t4_drained", 32'(exp_q.size() <= DEPTH), 1);

    // PC wrap past the top of the address space.
    saw_fffc = 1'b0; saw_wrap = 1'b0;
    force_redir = 1'b1; force_target = 32'hFFFF_FFF8;
    step();
    repeat (14) step();
    check("t5_wrap", 32'(saw_wrap), 1);

`ifdef IFETCH_ALIGN_CHECK_EN
    // Misaligned target halts fetch until an aligned redirect.
    force_redir = 1'b1; force_target = 32'h0000_0102;
    step();
    step();
    gnt_count = 0;
    repeat (6) step();
    check("t6_halt_err", 32'(bus.fetch_err_o), 1);
    check("t6_halt_gnts", 32'(gnt_count), 0);
    force_redir = 1'b1; force_target = 32'h0000_0200;
    step();
    step();
    pops = 0;
    repeat (12) step();
    check("t6_resume_err", 32'(bus.fetch_err_o), 0);
    check("t6_resume_progress", 32'(pops >= 1), 1);
`else
    // Low target bits are ignored: 0x102 fetches from 0x100.
    force_redir = 1'b1; force_target = 32'h0000_0102;
    step();
    pops = 0;
    repeat (12) step();
    check("t6_masked_progress", 32'(pops >= 2), 1);
    check("t6_err_tied", 32'(bus.fetch_err_o), 0);
`endif

    // Randomized traffic, each run starting from a reset with a stray response.
    total_pops = 0;
    for (int r = 0; r < 2; r++) begin
      set_knobs(int'($urandom_range(50, 100)), int'($urandom_range(50, 100)),
                int'($urandom_range(50, 100)), int'($urandom_range(1, 5)));
      do_reset(1'b1);
      repeat (1500) step();
      total_pops += pops;
    end
    check("rand_progress", 32'(total_pops >= 200), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
